// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, fetch FSM states and buffered-entry layout for the
// instruction fetch unit and its output buffer.
package instr_fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are word aligned; the low two bits are always cleared.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the redirect input, the instruction-memory request/response bus,
// the decode-side output stream and a debug view of the fetch FSM.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  // Handshakes: a memory request transfers on a cycle where imem_req and
  // imem_gnt are both high, and imem_addr holds until then; imem_rvalid is a
  // one-cycle response. A decode entry transfers on a cycle where if_valid and
  // if_ready are both high; if_valid never depends on if_ready.
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic               if_ready;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  fetch_state_e       state;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, state
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, state
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small shift-style FIFO of fetched entries; the head always sits in entry 0
// so the decode outputs come straight from a register.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic             pop_ok;
  logic [IDX_W-1:0] wr_idx;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop_ok = pop && !empty;
  // After a pop the entries shift down, so a same-cycle push lands one lower.
  assign wr_idx = IDX_W'(pop_ok ? count - 1'b1 : count);
  assign head   = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[wr_idx] <= din;
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, results
// buffered for decode, with branch redirect and flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
  parameter int              FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  granted_pc;
  logic             outstanding;
  logic             credit_ok;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     head;

  assign outstanding = (state == WAIT) || (state == DRAIN);
  // A new request may only start if its result is guaranteed a FIFO slot.
  assign credit_ok   = (int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH;
  assign push        = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid && !fifo_full;
  assign pop         = bus.if_valid && bus.if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= align_pc(RESET_PC);
      granted_pc <= '0;
    end else begin
      case (state)
        IDLE:  if (!bus.redirect_valid && credit_ok) state <= REQ;
        REQ: begin
          if (bus.imem_gnt) begin
            state      <= bus.redirect_valid ? DRAIN : WAIT;
            granted_pc <= fetch_pc;
            fetch_pc   <= fetch_pc + PC_W'(4);
          end else if (bus.redirect_valid) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid)         state <= IDLE;
          else if (bus.redirect_valid) state <= DRAIN;
        end
        DRAIN: if (bus.imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
      // The redirect target overrides the post-grant increment.
      if (bus.redirect_valid) fetch_pc <= align_pc(bus.redirect_pc);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   ('{pc: granted_pc, instr: bus.imem_rdata}),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.imem_req  = (state == REQ);
  assign bus.imem_addr = fetch_pc;
  assign bus.if_valid  = !fifo_empty;
  assign bus.if_pc     = head.pc;
  assign bus.if_instr  = head.instr;
  assign bus.state     = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for the basic fetch
// stream plus hand-written redirect, stall and reset sequences.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk;
  logic rst;
  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PC_W+INSTR_W-1:0] exp_q[$];
  int                      gap_q[$];

  logic            pend_valid;
  logic [PC_W-1:0] pend_addr;
  logic            mem_hold;

  typedef struct {
    logic       redir;
    logic [7:0] rpc;
    logic       gnt;
    logic       rdy;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {8'hC3, a, ~a, 8'h5A};
  endfunction

  function automatic vec_t mk(input logic redir, input logic [7:0] rpc, input logic gnt,
                              input logic e_req, input logic [7:0] e_addr,
                              input logic e_valid, input logic [7:0] e_pc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rdy = 1'b1;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock; also plays the memory: rvalid one cycle after each grant
  // unless mem_hold keeps the response pending.
  task automatic tick();
    logic            g;
    logic [PC_W-1:0] ga;
    @(negedge clk);
    g  = bus.imem_req && bus.imem_gnt && !rst;
    ga = bus.imem_addr;
    @(posedge clk);
    #1;
    if (g) begin
      pend_valid = 1'b1;
      pend_addr  = ga;
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (pend_valid && !mem_hold) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr);
      pend_valid      = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic check_vals);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_gnt       = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.if_ready       = rdy;
    pend_valid = 1'b0;
    mem_hold   = 1'b0;
    tick();
    tick();
    if (check_vals) begin
      chk("rst imem_req", 40'(bus.imem_req), 40'(0));
      chk("rst imem_addr", 40'(bus.imem_addr), 40'(8'h00));
      chk("rst if_valid", 40'(bus.if_valid), 40'(0));
      chk("rst if_pc", 40'(bus.if_pc), 40'(0));
      chk("rst if_instr", 40'(bus.if_instr), 40'(0));
      chk("rst state", 40'(bus.state), 40'(IDLE));
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic expect_entry(input logic [PC_W-1:0] pc, input int gap);
    exp_q.push_back({pc, mem_word(pc)});
    gap_q.push_back(gap);
  endtask

  // Consume expected entries in order; gap > 0 also checks cycles since the
  // previous accepted entry.
  task automatic run_sb(input int budget, input string name);
    int cyc  = 0;
    int last = -1;
    int g;
    logic [PC_W+INSTR_W-1:0] e;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (bus.if_valid && bus.if_ready) begin
        e = exp_q.pop_front();
        g = gap_q.pop_front();
        chk({name, " entry"}, {bus.if_pc, bus.if_instr}, e);
        if (g > 0 && last >= 0) chk({name, " gap"}, 40'(cyc - last), 40'(g));
        last = cyc;
      end
      tick();
      cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: %0d entries still pending after %0d cycles, required 0",
               name, exp_q.size(), cyc);
      exp_q.delete();
      gap_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle 0 is the first cycle with rst low.
    vecs[0]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 8'h00, 1, 1, 8'h00, 0, 8'h00);
    vecs[2]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[3]  = mk(0, 8'h00, 1, 0, 8'h00, 1, 8'h00);
    vecs[4]  = mk(0, 8'h00, 1, 1, 8'h04, 0, 8'h00);
    vecs[5]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[6]  = mk(0, 8'h00, 1, 0, 8'h00, 1, 8'h04);
    vecs[7]  = mk(0, 8'h00, 1, 1, 8'h08, 0, 8'h00);
    vecs[8]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[9]  = mk(0, 8'h00, 1, 0, 8'h00, 1, 8'h08);
    vecs[10] = mk(0, 8'h00, 1, 1, 8'h0C, 0, 8'h00);
    vecs[11] = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[12] = mk(0, 8'h00, 1, 0, 8'h00, 1, 8'h0C);
    // Redirect while requesting without a grant: request withdrawn.
    vecs[13] = mk(1, 8'h22, 0, 1, 8'h10, 0, 8'h00);
    vecs[14] = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[15] = mk(0, 8'h00, 1, 1, 8'h20, 0, 8'h00);
    vecs[16] = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[17] = mk(0, 8'h00, 1, 0, 8'h00, 1, 8'h20);
    // Redirect in the grant cycle: that response is drained and dropped.
    vecs[18] = mk(1, 8'h67, 1, 1, 8'h24, 0, 8'h00);
    vecs[19] = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[20] = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[21] = mk(0, 8'h00, 1, 1, 8'h64, 0, 8'h00);
    vecs[22] = mk(0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
    vecs[23] = mk(0, 8'h00, 1, 0, 8'h00, 1, 8'h64);

    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      if (i > 0) tick();
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      bus.imem_gnt       = vecs[i].gnt;
      bus.if_ready       = vecs[i].rdy;
      chk($sformatf("row%0d imem_req", i), 40'(bus.imem_req), 40'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("row%0d imem_addr", i), 40'(bus.imem_addr), 40'(vecs[i].e_addr));
      chk($sformatf("row%0d if_valid", i), 40'(bus.if_valid), 40'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("row%0d if_pc", i), 40'(bus.if_pc), 40'(vecs[i].e_pc));
        chk($sformatf("row%0d if_instr", i), 40'(bus.if_instr), 40'(mem_word(vecs[i].e_pc)));
      end
    end
    bus.redirect_valid = 1'b0;

    // Address wrap from F8, one instruction every three cycles.
    do_reset(1'b1, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hF9;
    tick();
    bus.redirect_valid = 1'b0;
    expect_entry(8'hF8, 0);
    expect_entry(8'hFC, 3);
    expect_entry(8'h00, 3);
    run_sb(40, "wrap");

    // Decode stalled: two entries buffered, no further requests.
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i >= 5) chk($sformatf("stall c%0d imem_req", i), 40'(bus.imem_req), 40'(0));
    end
    chk("stall if_valid", 40'(bus.if_valid), 40'(1));
    chk("stall if_pc", 40'(bus.if_pc), 40'(8'h00));
    bus.if_ready = 1'b1;
    expect_entry(8'h00, 0);
    expect_entry(8'h04, 1);
    expect_entry(8'h08, 3);
    run_sb(30, "stall");

    // Redirect while waiting for data: stale response dropped.
    do_reset(1'b1, 1'b0);
    tick();
    chk("rw c1 imem_addr", 40'(bus.imem_addr), 40'(8'h00));
    mem_hold = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h43;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rw c3 if_valid", 40'(bus.if_valid), 40'(0));
    chk("rw c3 imem_req", 40'(bus.imem_req), 40'(0));
    mem_hold = 1'b0;
    tick();
    tick();
    tick();
    chk("rw c6 imem_req", 40'(bus.imem_req), 40'(1));
    chk("rw c6 imem_addr", 40'(bus.imem_addr), 40'(8'h40));
    expect_entry(8'h40, 0);
    run_sb(20, "redir_wait");

    // Reset in the middle of a transaction, response arrives after release.
    do_reset(1'b1, 1'b0);
    tick();
    mem_hold = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rl rst state", 40'(bus.state), 40'(IDLE));
    chk("rl rst imem_req", 40'(bus.imem_req), 40'(0));
    tick();
    tick();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    pend_valid = 1'b0;
    mem_hold   = 1'b0;
    #1;
    chk("rl r0 if_valid", 40'(bus.if_valid), 40'(0));
    tick();
    chk("rl r1 if_valid", 40'(bus.if_valid), 40'(0));
    chk("rl r1 imem_req", 40'(bus.imem_req), 40'(1));
    chk("rl r1 imem_addr", 40'(bus.imem_addr), 40'(8'h00));
    tick();
    chk("rl r2 if_valid", 40'(bus.if_valid), 40'(0));
    expect_entry(8'h00, 0);
    run_sb(10, "rst_late");

    // Redirect on the same cycle as a pop from a full buffer.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("rp full if_valid", 40'(bus.if_valid), 40'(1));
    chk("rp full if_pc", 40'(bus.if_pc), 40'(8'h00));
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h81;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rp if_valid", 40'(bus.if_valid), 40'(0));
    chk("rp fetch_pc", 40'(bus.imem_addr), 40'(8'h80));
    chk("rp imem_req", 40'(bus.imem_req), 40'(0));
    tick();
    chk("rp req2 imem_req", 40'(bus.imem_req), 40'(1));
    chk("rp req2 imem_addr", 40'(bus.imem_addr), 40'(8'h80));
    expect_entry(8'h80, 0);
    run_sb(10, "redir_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
